data_ram_pipe: RTL and testbench
================================

DATA_RAM_PIPE -- requirements
Module: data_ram_pipe

Interface
REQ-001 SHALL have parameter N_DATA, default 32, data width in bits, multiple of 8.
REQ-002 SHALL have parameter N_ADDR, default 10, word-address width; depth = 2**N_ADDR words.
REQ-003 SHALL have port i_clk input 1 system clock, all logic on rising edge.
REQ-004 SHALL have port i_rst_n input 1, synchronous active-low reset.
REQ-005 SHALL have port i_req input 1, access request.
REQ-006 SHALL have port i_we input 1, 1=write, 0=read.
REQ-007 SHALL have port i_addr input N_ADDR, word address.
REQ-008 SHALL have port i_data input N_DATA, write data.
REQ-009 SHALL have port i_sel input N_DATA/8, byte-lane enables.
REQ-010 SHALL have port i_perr_inj input 1, parity error injection on write.
REQ-011 SHALL have port o_ready output 1, block accepts a request this cycle.
REQ-012 SHALL have port o_busy output 1, clear sweep in progress.
REQ-013 SHALL have port o_rvalid output 1, read data valid pulse.
REQ-014 SHALL have port o_data output N_DATA, read data.
REQ-015 SHALL have port o_perr output 1, parity error flag, valid with o_rvalid.

Function
REQ-016 SHALL implement FSM states CLEAR and IDLE; CLEAR -> IDLE after address 2**N_ADDR-1 is cleared; IDLE is held until reset.
REQ-017 SHALL, in CLEAR, write all-zero data and matching parity to one word per cycle from address 0 upward, with o_busy=1 and o_ready=0; the sweep takes 2**N_ADDR cycles.
REQ-018 SHALL drive o_ready=1 and o_busy=0 in IDLE; a request is accepted iff i_req && o_ready.
REQ-019 SHALL, on an accepted write, update only byte lanes k with i_sel[k]=1 (lane k = i_data[8k+7:8k]) at that clock edge; i_sel=0 leaves memory unchanged.
REQ-020 SHALL, on an accepted read, assert o_rvalid for exactly one cycle in the following cycle, with o_data = stored word at that address; read ignores i_sel.
REQ-021 SHALL hold o_data at the last read value until the next accepted read; writes and idle cycles do not change o_data.
REQ-022 SHALL return data written in cycle N to a read accepted in cycle N+1 or later at the same address.
REQ-023 SHALL accept back-to-back requests every cycle in IDLE, with no bubbles.
REQ-024 SHALL ignore i_req, i_we, i_addr, i_data, and i_sel during CLEAR.

Reset
REQ-025 SHALL, when i_rst_n=0 at a clock edge, enter CLEAR with the sweep counter at 0, and set o_rvalid=0, o_perr=0, o_data=0, o_ready=0, o_busy=1.
REQ-026 SHALL restart the sweep from address 0 when reset is asserted mid-CLEAR, and drop any pending o_rvalid when reset is asserted mid-read.

Configuration
REQ-027 SHALL, with macro DATA_RAM_PARITY_EN defined, store one even-parity bit per byte, recompute it on every written lane, invert the stored bits of written lanes when i_perr_inj=1, and raise o_perr together with o_rvalid if any byte mismatches.
REQ-028 SHALL, without DATA_RAM_PARITY_EN, contain no parity storage, tie o_perr to 0, and ignore i_perr_inj; all other behaviour is identical.

Structure
REQ-029 SHALL take default widths and the FSM state enum typedef (CLEAR, IDLE) from shared package data_ram_pkg.
REQ-030 SHALL place the sweep counter and FSM in one sub-module, data_ram_clr_fsm; the storage array and read register SHALL stay in the top module.

Verification
REQ-031 SHALL verify reset-to-ready latency: with N_ADDR=4, deassert reset -> o_busy=1 for exactly 16 cycles, then o_ready=1; a read of any address then returns 0.
REQ-032 SHALL verify byte lanes: writes of 32'h11223344 to address 'hF with i_sel 4'b1000, 4'b0100, 4'b0010, and 4'b0001 in turn, each followed by a read, return 32'h11000000, 32'h11220000, 32'h11223300, and 32'h11223344.
REQ-033 SHALL verify back-to-back operation: a write of 32'hDEADBEEF with i_sel=4'hF to address 3 in cycle N and a read of address 3 in cycle N+1 -> o_rvalid=1 in cycle N+2 with o_data=32'hDEADBEEF, and o_data is held through later writes.
REQ-034 SHALL verify reset mid-sweep: reset asserted in clear cycle 7 -> the sweep restarts at 0 and o_ready rises 16 cycles after reset deassertion; requests issued during CLEAR have no effect.
REQ-035 SHALL verify parity, with DATA_RAM_PARITY_EN: a write to address 5 with i_perr_inj=1 followed by a read -> o_perr=1 with o_rvalid; rewriting address 5 with i_perr_inj=0 and reading -> o_perr=0; without the macro, o_perr stays 0 throughout.

Source files
------------

// File: rtl/data_ram_pkg.sv
// data_ram_pkg: shared default widths and clear-FSM state type for data_ram_pipe
package data_ram_pkg;
  localparam int N_DATA_DEF = 32;
  localparam int N_ADDR_DEF = 10;
  typedef enum logic {CLEAR, IDLE} state_t;
endpackage

// File: rtl/data_ram_if.sv
// data_ram_if: request/response bus of data_ram_pipe
interface data_ram_if
  import data_ram_pkg::*;
#(
  parameter int N_DATA = N_DATA_DEF,
  parameter int N_ADDR = N_ADDR_DEF
);
  logic                i_req;
  logic                i_we;
  logic [N_ADDR-1:0]   i_addr;
  logic [N_DATA-1:0]   i_data;
  logic [N_DATA/8-1:0] i_sel;
  logic                i_perr_inj;
  logic                o_ready;
  logic                o_busy;
  logic                o_rvalid;
  logic [N_DATA-1:0]   o_data;
  logic                o_perr;
  modport master (
    output i_req, i_we, i_addr, i_data, i_sel, i_perr_inj,
    input  o_ready, o_busy, o_rvalid, o_data, o_perr
  );
  modport slave (
    input  i_req, i_we, i_addr, i_data, i_sel, i_perr_inj,
    output o_ready, o_busy, o_rvalid, o_data, o_perr
  );
endinterface

// File: rtl/data_ram_clr_fsm.sv
// data_ram_clr_fsm: power-up clear sweep counter and CLEAR/IDLE state machine
module data_ram_clr_fsm
  import data_ram_pkg::*;
#(
  parameter int N_ADDR = N_ADDR_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_clr_we,
  output logic [N_ADDR-1:0] o_clr_addr,
  output logic              o_ready,
  output logic              o_busy
);
  state_t            state_q, state_d;
  logic [N_ADDR-1:0] cnt_q, cnt_d;
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    o_busy     = state_q == CLEAR;
    o_ready    = state_q == IDLE;
    o_clr_we   = o_busy;
    o_clr_addr = cnt_q;
    cnt_d      = o_busy ? cnt_q + 1'b1 : cnt_q;
    state_d    = (o_busy && &cnt_q) ? IDLE : state_q;
  end
endmodule

// File: rtl/data_ram_pipe.sv
// data_ram_pipe: byte-lane RAM with power-up clear sweep; define DATA_RAM_PARITY_EN for per-byte parity
module data_ram_pipe
  import data_ram_pkg::*;
#(
  parameter int N_DATA = N_DATA_DEF,
  parameter int N_ADDR = N_ADDR_DEF
) (
  input logic      i_clk,
  input logic      i_rst_n,
  data_ram_if.slave bus
);
  localparam int N_BYTE = N_DATA / 8;
  logic              clr_we, ready, busy, acc, rd, rvalid_q;
  logic [N_ADDR-1:0] clr_addr;
  logic [N_DATA-1:0] data_q;
  logic [N_DATA-1:0] mem [2**N_ADDR];
  data_ram_clr_fsm #(.N_ADDR(N_ADDR)) u_clr (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .o_clr_we   (clr_we),
    .o_clr_addr (clr_addr),
    .o_ready    (ready),
    .o_busy     (busy)
  );
  assign acc           = bus.i_req && ready;
  assign rd            = acc && !bus.i_we;
  assign bus.o_ready   = ready;
  assign bus.o_busy    = busy;
  assign bus.o_rvalid  = rvalid_q;
  assign bus.o_data    = data_q;
  always_ff @(posedge i_clk)
    if (clr_we) mem[clr_addr] <= '0;
    else if (acc && bus.i_we)
      for (int k = 0; k < N_BYTE; k++)
        if (bus.i_sel[k]) mem[bus.i_addr][8*k +: 8] <= bus.i_data[8*k +: 8];
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      rvalid_q <= 1'b0;
      data_q   <= '0;
    end else begin
      rvalid_q <= rd;
      if (rd) data_q <= mem[bus.i_addr];
    end
`ifdef DATA_RAM_PARITY_EN
  logic [N_BYTE-1:0] par [2**N_ADDR];
  logic [N_BYTE-1:0] par_bad;
  logic              perr_q;
  always_comb begin
    par_bad = '0;
    for (int k = 0; k < N_BYTE; k++)
      par_bad[k] = par[bus.i_addr][k] ^ (^mem[bus.i_addr][8*k +: 8]);
  end
  always_ff @(posedge i_clk)
    if (clr_we) par[clr_addr] <= '0;
    else if (acc && bus.i_we)
      for (int k = 0; k < N_BYTE; k++)
        if (bus.i_sel[k]) par[bus.i_addr][k] <= (^bus.i_data[8*k +: 8]) ^ bus.i_perr_inj;
  always_ff @(posedge i_clk)
    if (!i_rst_n) perr_q <= 1'b0;
    else if (rd) perr_q <= |par_bad;
  assign bus.o_perr = perr_q;
`else
  logic unused_perr_inj;
  assign unused_perr_inj = bus.i_perr_inj;
  assign bus.o_perr      = 1'b0;
`endif
endmodule

// File: tb/tb_data_ram_pipe.sv
// tb_data_ram_pipe: randomized self-checking bench for data_ram_pipe against an array model
module tb_data_ram_pipe;
  localparam int NA = 4;
  localparam int ND = 32;
  localparam int DEPTH = 16;
`ifdef DATA_RAM_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif
  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [DEPTH];
  logic [3:0]  bad [DEPTH];
  logic [31:0] held;
  logic        held_perr;
  logic [31:0] lane_exp [4] = '{32'h11000000, 32'h11220000, 32'h11223300, 32'h11223344};
  data_ram_if #(.N_DATA(ND), .N_ADDR(NA)) bus ();
  data_ram_pipe #(.N_DATA(ND), .N_ADDR(NA)) dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus));
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask
  task automatic clear_model;
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = '0;
      bad[i]   = '0;
    end
    held      = '0;
    held_perr = 1'b0;
  endtask
  task automatic step(input logic req, input logic we, input logic [NA-1:0] a,
                      input logic [31:0] d, input logic [3:0] sel, input logic inj);
    logic rv;
    bus.i_req = req; bus.i_we = we; bus.i_addr = a; bus.i_data = d; bus.i_sel = sel; bus.i_perr_inj = inj;
    chk("ready", bus.o_ready, 1);
    rv = req && !we;
    if (rv) begin
      held      = model[a];
      held_perr = PAR_EN && (|bad[a]);
    end
    if (req && we)
      for (int k = 0; k < 4; k++)
        if (sel[k]) begin
          model[a][8*k +: 8] = d[8*k +: 8];
          bad[a][k] = inj;
        end
    tick;
    bus.i_req = 1'b0;
    chk("rvalid", bus.o_rvalid, rv);
    chk("rdata", bus.o_data, held);
    if (rv) chk("perr", bus.o_perr, held_perr);
  endtask
  task automatic noise;
    bus.i_req = 1'b1; bus.i_we = 1'($urandom); bus.i_addr = 4'($urandom);
    bus.i_data = $urandom; bus.i_sel = 4'($urandom); bus.i_perr_inj = 1'($urandom);
  endtask
  task automatic sweep(input bit with_noise);
    int n = 0;
    while (bus.o_busy === 1'b1 && n < 64) begin
      if (with_noise) noise();
      tick;
      n++;
      chk("clr_ready", bus.o_ready, !bus.o_busy);
      chk("clr_rvalid", bus.o_rvalid, 0);
    end
    bus.i_req = 1'b0;
    chk("sweep_len", n, 16);
    chk("ready_after", bus.o_ready, 1);
    chk("busy_after", bus.o_busy, 0);
  endtask
  initial begin
    bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_addr = '0; bus.i_data = '0; bus.i_sel = '0; bus.i_perr_inj = 1'b0;
    clear_model();
    tick;
    tick;
    chk("rst_ready", bus.o_ready, 0);
    chk("rst_busy", bus.o_busy, 1);
    chk("rst_rvalid", bus.o_rvalid, 0);
    chk("rst_data", bus.o_data, 0);
    chk("rst_perr", bus.o_perr, 0);
    i_rst_n = 1'b1;
    sweep(0);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 4'(i), 32'hFFFFFFFF, 4'hF, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 4'hF, 32'h11223344, 4'b1000 >> i, 0);
      step(1, 0, 4'hF, $urandom, 4'h0, 0);
      chk("lane_const", bus.o_data, lane_exp[i]);
    end
    step(1, 1, 4'hF, 32'hAAAAAAAA, 4'h0, 0);
    step(1, 0, 4'hF, 0, 4'h0, 0);
    chk("sel_zero", bus.o_data, 32'h11223344);
    step(1, 1, 4'd3, 32'hDEADBEEF, 4'hF, 0);
    step(1, 0, 4'd3, 0, 4'h5, 0);
    chk("b2b_data", bus.o_data, 32'hDEADBEEF);
    step(1, 1, 4'd3, $urandom, 4'hF, 0);
    step(1, 1, 4'd7, $urandom, 4'hF, 0);
    step(0, 0, 4'd3, 0, 4'h0, 0);
    chk("b2b_hold", bus.o_data, 32'hDEADBEEF);
    step(1, 1, 4'd5, $urandom, 4'hF, 1);
    step(1, 0, 4'd5, 0, 4'h0, 0);
    chk("perr_inj", bus.o_perr, PAR_EN);
    step(1, 1, 4'd5, $urandom, 4'hF, 0);
    step(1, 0, 4'd5, 0, 4'h0, 0);
    chk("perr_clean", bus.o_perr, 0);
    step(1, 1, 4'd6, $urandom, 4'h2, 1);
    step(1, 0, 4'd6, 0, 4'h0, 0);
    chk("perr_lane", bus.o_perr, PAR_EN);
    repeat (400)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom), $urandom,
           4'($urandom), 1'($urandom_range(0, 7) == 0));
    for (int i = 0; i < DEPTH; i++) step(1, 1, 4'(i), $urandom | 32'h1, 4'hF, 0);
    bus.i_req = 1'b1; bus.i_we = 1'b0; bus.i_addr = 4'd2;
    i_rst_n = 1'b0;
    tick;
    bus.i_req = 1'b0;
    chk("midrd_rvalid", bus.o_rvalid, 0);
    chk("midrd_data", bus.o_data, 0);
    chk("midrd_busy", bus.o_busy, 1);
    i_rst_n = 1'b1;
    repeat (7) begin
      noise();
      tick;
      chk("noise_rvalid", bus.o_rvalid, 0);
    end
    i_rst_n = 1'b0;
    noise();
    tick;
    chk("midsw_busy", bus.o_busy, 1);
    chk("midsw_ready", bus.o_ready, 0);
    i_rst_n = 1'b1;
    sweep(1);
    clear_model();
    for (int i = 0; i < DEPTH; i++) step(1, 0, 4'(i), $urandom, 4'hF, 0);
    step(1, 1, 4'd9, 32'hCAFEF00D, 4'hF, 0);
    step(1, 0, 4'd9, 0, 4'h0, 0);
    chk("post_clear_rw", bus.o_data, 32'hCAFEF00D);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
